// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
//
// Round-robin owner of the register bank write port. Up to NREQ requesters
// (ALU result, load path, I/O, ...) hold a level request together with their
// data and target address. The arbiter samples them only while idle, picks one
// winner starting from the round-robin pointer, and then spends one cycle
// driving the bank (LOAD) and one cycle acknowledging the requester (ACK).
// Every output comes straight from a flop.
//
// Optional build macro:
//   REG_ZERO_PROTECT_EN - register 0 is read-only; a write to address 0
//                         produces no load strobe and is acknowledged with err.
//
// Ports:
//   clk       in   clock, rising edge
//   reset_n   in   synchronous active-low reset
//   req       in   [NREQ]         level request per requester, held until ack
//   wr_data   in   [NREQ*WIDTH]   requester i data at [i*WIDTH +: WIDTH]
//   wr_addr   in   [NREQ*ADDR_W]  requester i address at [i*ADDR_W +: ADDR_W]
//   gnt       out  [NREQ]         one-hot owner of the port during LOAD/ACK
//   ack       out  [NREQ]         one-cycle completion pulse to the owner
//   err       out                 coincident with ack when the write is rejected
//   reg_load  out  [NREGS]        one-hot load strobe into the bank
//   reg_din   out  [WIDTH]        data bus into the bank, holds between writes
//   busy      out                 high whenever a transfer is in progress
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
    parameter int WIDTH  = 8,
    parameter int NREQ   = 4,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    wr_data,
    input  logic [NREQ*ADDR_W-1:0]   wr_addr,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          ack,
    output logic                     err,
    output logic [NREGS-1:0]         reg_load,
    output logic [WIDTH-1:0]         reg_din,
    output logic                     busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        ACK  = 2'b10
    } state_t;

    state_t             state_q,    state_d;
    logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [IDX_W-1:0]   win_q,      win_d;
    logic [ADDR_W-1:0]  addr_q,     addr_d;
    logic [NREQ-1:0]    gnt_q,      gnt_d;
    logic [NREQ-1:0]    ack_q,      ack_d;
    logic               err_q,      err_d;
    logic [NREGS-1:0]   reg_load_q, reg_load_d;
    logic [WIDTH-1:0]   reg_din_q,  reg_din_d;
    logic               busy_q,     busy_d;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [WIDTH-1:0]   sel_data;
    logic [ADDR_W-1:0]  sel_addr;

    // A write is rejected when it targets a register the bank does not have
    // (or, with protection, the hard-wired zero register).
    function automatic logic addr_rejected(input logic [ADDR_W-1:0] a);
        logic rej;
        rej = (int'(a) >= NREGS);
`ifdef REG_ZERO_PROTECT_EN
        rej = rej || (a == '0);
`else
        rej = rej || 1'b0;
`endif
        return rej;
    endfunction

    function automatic logic [NREGS-1:0] load_strobe(input logic [ADDR_W-1:0] a);
        logic [NREGS-1:0] s;
        s = '0;
        if (!addr_rejected(a)) begin
            for (int r = 0; r < NREGS; r++) begin
                if (int'(a) == r) s[r] = 1'b1;
            end
        end
        return s;
    endfunction

    // Winner search: first set request bit at or above rr_ptr, wrapping.
    always_comb begin
        int j;
        j         = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!sel_found && req[j]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(j);
            end
        end
    end

    assign sel_data = wr_data[int'(sel_idx)*WIDTH +: WIDTH];
    assign sel_addr = wr_addr[int'(sel_idx)*ADDR_W +: ADDR_W];

    // Next state and next registered outputs. The output flops are loaded with
    // the values for the state being entered, so they line up with state_q.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        win_d      = win_q;
        addr_d     = addr_q;
        gnt_d      = '0;
        ack_d      = '0;
        err_d      = 1'b0;
        reg_load_d = '0;
        reg_din_d  = reg_din_q;
        busy_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    win_d          = sel_idx;
                    addr_d         = sel_addr;
                    gnt_d[sel_idx] = 1'b1;
                    reg_din_d      = sel_data;
                    reg_load_d     = load_strobe(sel_addr);
                    busy_d         = 1'b1;
                    state_d        = LOAD;
                end
            end
            LOAD: begin
                gnt_d[win_q] = 1'b1;
                ack_d[win_q] = 1'b1;
                err_d        = addr_rejected(addr_q);
                busy_d       = 1'b1;
                state_d      = ACK;
            end
            ACK: begin
                rr_ptr_d = (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            win_q      <= '0;
            addr_q     <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            reg_load_q <= '0;
            reg_din_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            win_q      <= win_d;
            addr_q     <= addr_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            reg_load_q <= reg_load_d;
            reg_din_q  <= reg_din_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign reg_load = reg_load_q;
    assign reg_din  = reg_din_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_write_arbiter
//
// Scoreboard bench for reg_write_arbiter (NREQ=4, NREGS=6 so out-of-range
// addresses 6 and 7 are reachable). A transfer-level model decides, at every
// rising edge, whether a new transfer starts and pushes the expected transfer
// into a queue; a monitor on the falling edge pops and compares whenever the
// DUT shows a transfer.
// -----------------------------------------------------------------------------
module tb_reg_write_arbiter;

    localparam int WIDTH  = 8;
    localparam int NREQ   = 4;
    localparam int NREGS  = 6;
    localparam int ADDR_W = 3;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   wr_data;
    logic [NREQ*ADDR_W-1:0]  wr_addr;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         ack;
    logic                    err;
    logic [NREGS-1:0]        reg_load;
    logic [WIDTH-1:0]        reg_din;
    logic                    busy;

    reg_write_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .NREGS (NREGS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .wr_data (wr_data),
        .wr_addr (wr_addr),
        .gnt     (gnt),
        .ack     (ack),
        .err     (err),
        .reg_load(reg_load),
        .reg_din (reg_din),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               w;
        logic [WIDTH-1:0] d;
        logic [NREGS-1:0] load;
        logic             err;
        int               cyc;
    } xfer_t;

    xfer_t sb[$];
    int    order[$];
    int    checks = 0;
    int    fails  = 0;
    int    cyc    = 0;
    int    rst_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, got, expv, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // A transfer occupies three edges: the sampling edge plus LOAD and ACK.
    // The pointer moves past the winner once the transfer has finished.
    initial begin
        int m_ptr, m_busy, m_next;
        m_ptr = 0; m_busy = 0; m_next = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset_n) begin
                m_ptr = 0;
                m_busy = 0;
                sb.delete();
                rst_cnt++;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_ptr = m_next;
            end else if (req != 0) begin
                xfer_t e;
                int w, a;
                bit rej;
                w = -1;
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                a = int'(wr_addr[w*ADDR_W +: ADDR_W]);
                rej = (a >= NREGS);
`ifdef REG_ZERO_PROTECT_EN
                if (a == 0) rej = 1'b1;
`endif
                e.w    = w;
                e.d    = wr_data[w*WIDTH +: WIDTH];
                e.load = rej ? '0 : NREGS'(1 << a);
                e.err  = rej;
                e.cyc  = cyc;
                sb.push_back(e);
                m_next = (w + 1) % NREQ;
                m_busy = 2;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int    phase, rst_seen;
        xfer_t cur;
        logic [WIDTH-1:0] din_hold;
        phase = 0; rst_seen = 0; din_hold = '0;
        cur = '{w: 0, d: '0, load: '0, err: 1'b0, cyc: 0};
        forever begin
            @(negedge clk);
            if (rst_cnt != rst_seen) begin
                rst_seen = rst_cnt;
                phase    = 0;
                din_hold = '0;
                chk("reset_gnt", 64'(gnt), 0);
                chk("reset_ack", 64'(ack), 0);
                chk("reset_err", 64'(err), 0);
                chk("reset_reg_load", 64'(reg_load), 0);
                chk("reset_reg_din", 64'(reg_din), 0);
                chk("reset_busy", 64'(busy), 0);
            end else if (phase == 0) begin
                if (gnt != 0 || ack != 0 || reg_load != 0 || busy) begin
                    if (sb.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL unexpected_xfer gnt=%b load=%b expected none (cycle %0d)", gnt, reg_load, cyc);
                    end else begin
                        cur = sb.pop_front();
                        chk("load_latency", 64'(cyc), 64'(cur.cyc));
                        chk("load_gnt", 64'(gnt), 64'(1 << cur.w));
                        chk("load_ack", 64'(ack), 0);
                        chk("load_err", 64'(err), 0);
                        chk("load_reg_load", 64'(reg_load), 64'(cur.load));
                        chk("load_reg_din", 64'(reg_din), 64'(cur.d));
                        chk("load_busy", 64'(busy), 1);
                        din_hold = cur.d;
                        phase = 1;
                    end
                end else begin
                    if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                        checks++; fails++;
                        $display("FAIL missing_xfer requester=%0d got none (cycle %0d)", sb[0].w, cyc);
                        void'(sb.pop_front());
                    end
                    chk("idle_reg_din", 64'(reg_din), 64'(din_hold));
                    chk("idle_err", 64'(err), 0);
                end
            end else begin
                chk("ack_gnt", 64'(gnt), 64'(1 << cur.w));
                chk("ack_ack", 64'(ack), 64'(1 << cur.w));
                chk("ack_err", 64'(err), 64'(cur.err));
                chk("ack_reg_load", 64'(reg_load), 0);
                chk("ack_reg_din", 64'(reg_din), 64'(cur.d));
                chk("ack_busy", 64'(busy), 1);
                order.push_back(cur.w);
                phase = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    // One clock step. Requesters drop req as soon as they see their ack; in
    // random mode they also raise new requests and sometimes drop early.
    task automatic cycle(input bit rnd);
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
                req[i] = 1'b0;
            end else if (rnd) begin
                if (req[i] && gnt[i] && $urandom_range(3) == 0) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(9) < 3) begin
                    req[i] = 1'b1;
                    wr_data[i*WIDTH +: WIDTH]   = WIDTH'($urandom);
                    wr_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
                end
            end
        end
    endtask

    task automatic serve_one(input int r, input logic [WIDTH-1:0] d, input logic [ADDR_W-1:0] a);
        wr_data[r*WIDTH +: WIDTH]   = d;
        wr_addr[r*ADDR_W +: ADDR_W] = a;
        req[r] = 1'b1;
        for (int k = 0; k < 10 && req != 0; k++) cycle(1'b0);
        chk("drop_timeout", 64'(req), 0);
        cycle(1'b0);
        cycle(1'b0);
    endtask

    initial begin
        logic [NREQ-1:0] prev;
        reset_n = 1'b0;
        req     = '1;
        wr_data = '0;
        wr_addr = '0;

        // Reset with every request raised: nothing may be served.
        cycle(1'b0);
        cycle(1'b0);
        reset_n = 1'b1;
        req     = '0;
        cycle(1'b0);

        // Single write, then an out-of-range write from requester 1.
        serve_one(2, 8'hA5, 3'd3);
        serve_one(1, 8'h5A, 3'd7);

        // Reset on the edge that would start a transfer; pointer returns to 0.
        wr_data[3*WIDTH +: WIDTH] = 8'h11; wr_addr[3*ADDR_W +: ADDR_W] = 3'd2;
        wr_data[1*WIDTH +: WIDTH] = 8'h22; wr_addr[1*ADDR_W +: ADDR_W] = 3'd4;
        req     = 4'b1010;
        reset_n = 1'b0;
        cycle(1'b0);
        reset_n = 1'b1;
        for (int k = 0; k < 10 && req != 0; k++) cycle(1'b0);
        req = '0;
        for (int k = 0; k < 4; k++) cycle(1'b0);

        // Plain reset then all requests held: strictly rotating service.
        reset_n = 1'b0;
        cycle(1'b0);
        reset_n = 1'b1;
        cycle(1'b0);
        for (int i = 0; i < NREQ; i++) begin
            wr_data[i*WIDTH +: WIDTH]   = WIDTH'(8'h30 + i);
            wr_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(i + 1);
        end
        order.delete();
        req = '1;
        for (int k = 0; k < 16; k++) begin
            prev = req;
            cycle(1'b0);
            req = req | ~prev;
        end
        req = '0;
        for (int k = 0; k < 5; k++) cycle(1'b0);
        chk("rr_count", 64'(order.size() >= 5), 1);
        if (order.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("rr_order", 64'(order[k]), 64'(k % NREQ));
        end

        // Write to register 0.
        serve_one(0, 8'h3C, 3'd0);

        // Randomised traffic.
        for (int k = 0; k < 1500; k++) cycle(1'b1);
        for (int k = 0; k < 40 && (req != 0 || busy); k++) begin
            cycle(1'b0);
            req = '0;
        end
        for (int k = 0; k < 4; k++) cycle(1'b0);
        chk("scoreboard_empty", 64'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
